sync_strobe_gen: RTL and testbench

Eight-channel programmable strobe generator that sits directly upstream of the 8-bit registered fan-out line stage. On each accepted sync trigger it produces up to eight pulses on its `out` bus, each with its own delay and width in clock cycles. The bus drives the fan-out stage's 8-bit input, which retimes it and splits it into individual lines. Per-channel delay and width are loaded through a simple write port into shadow registers. Shadow values are copied to the active set only when a trigger is accepted.

---
 rtl/sync_strobe_gen.sv | 188 ++++++++++++++++++
 tb/tb_sync_strobe_gen.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_strobe_gen.sv
// rtl/sync_strobe_gen.sv - eight-channel programmable strobe generator
//
// Purpose: on each accepted sync trigger, drives up to eight pulses on the
// registered out bus, each with its own delay and width in clock cycles.
// Delay/width values are written into shadow registers and copied to the
// active set only when a trigger is accepted.
//
// Ports:
//   clk       system clock
//   rst       synchronous reset, active-high
//   trig      sync trigger, asynchronous to clk; rising edge starts a run
//   abort     synchronous; ends a run immediately without done
//   cfg_we    config write strobe
//   cfg_addr  [3]=0 delay, [3]=1 width; [2:0] channel
//   cfg_data  config write data
//   out       registered strobe bus
//   busy      high while a run is active
//   done      one-cycle pulse at normal run completion
//   ovr       sticky: trigger edge arrived while busy
module sync_strobe_gen #(
  parameter int DLY_W = 16,
  parameter int WID_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trig,
  input  logic        abort,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [15:0] cfg_data,
  output logic [7:0]  out,
  output logic        busy,
  output logic        done,
  output logic        ovr
);

  // One extra bit so dly+wid never wraps.
  localparam int CW = DLY_W + 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state, state_nxt;
  logic              s1, s2, s3;
  logic              trig_edge;
  logic              accept;
  logic [DLY_W-1:0]  sh_dly  [8];
  logic [WID_W-1:0]  sh_wid  [8];
  logic [DLY_W-1:0]  act_dly [8];
  logic [WID_W-1:0]  act_wid [8];
  logic [CW-1:0]     sh_end  [8];
  logic [CW-1:0]     act_end [8];
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     run_len, run_len_nxt;
  logic [7:0]        out_nxt;
  logic              done_nxt;

  // Trigger synchronizer plus one delay flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= trig;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign trig_edge = s2 & ~s3;
  assign accept    = (state == IDLE) && trig_edge;

  // Shadow registers; writable in any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        sh_dly[i] <= '0;
        sh_wid[i] <= '0;
      end
    end else if (cfg_we) begin
      if (cfg_addr[3])
        sh_wid[cfg_addr[2:0]] <= cfg_data[WID_W-1:0];
      else
        sh_dly[cfg_addr[2:0]] <= cfg_data[DLY_W-1:0];
    end
  end

  // End points of each channel pulse, at extended width.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      sh_end[i]  = {1'b0, sh_dly[i]}  + {{(CW-WID_W){1'b0}}, sh_wid[i]};
      act_end[i] = {1'b0, act_dly[i]} + {{(CW-WID_W){1'b0}}, act_wid[i]};
    end
  end

  // Run length from the shadow set: latest end among enabled channels.
  always_comb begin
    run_len_nxt = '0;
    for (int i = 0; i < 8; i++) begin
      if ((sh_wid[i] != '0) && (sh_end[i] > run_len_nxt))
        run_len_nxt = sh_end[i];
    end
  end

  // Active set is captured on accept; the NBA copy picks up the pre-write
  // shadow value, so a write in the accept cycle waits for the next run.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        act_dly[i] <= '0;
        act_wid[i] <= '0;
      end
      run_len <= '0;
    end else if (accept) begin
      for (int i = 0; i < 8; i++) begin
        act_dly[i] <= sh_dly[i];
        act_wid[i] <= sh_wid[i];
      end
      run_len <= run_len_nxt;
    end
  end

  // Run counter: zeroed on accept, advances every RUN cycle.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (accept)
      cnt <= '0;
    else if (state == RUN)
      cnt <= cnt + 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // FSM next state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (trig_edge) state_nxt = RUN;
      RUN: begin
        if (abort)
          state_nxt = IDLE;
        else if (cnt == run_len)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs (registered below). Abort suppresses both pulses and done.
  always_comb begin
    out_nxt  = '0;
    done_nxt = 1'b0;
    if ((state == RUN) && !abort) begin
      if (cnt == run_len) begin
        done_nxt = 1'b1;
      end else begin
        for (int i = 0; i < 8; i++)
          out_nxt[i] = (act_wid[i] != '0) &&
                       (cnt >= {1'b0, act_dly[i]}) &&
                       (cnt < act_end[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out  <= '0;
      done <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      out  <= out_nxt;
      done <= done_nxt;
      // Edges during a run are dropped, not queued; only flagged.
      if ((state == RUN) && trig_edge)
        ovr <= 1'b1;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_sync_strobe_gen.sv
// tb/tb_sync_strobe_gen.sv - self-checking bench for sync_strobe_gen
module tb_sync_strobe_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trig = 1'b0;
  logic        abort = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic [7:0]  out;
  logic        busy;
  logic        done;
  logic        ovr;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: shadow set, active set, sticky overrun.
  int m_sh_dly [8];
  int m_sh_wid [8];
  int m_act_dly [8];
  int m_act_wid [8];
  bit m_ovr;

  sync_strobe_gen #(.DLY_W(16), .WID_W(8)) dut (
    .clk(clk), .rst(rst), .trig(trig), .abort(abort),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .out(out), .busy(busy), .done(done), .ovr(ovr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk(input bit o, input bit b, input bit d, input logic [7:0] q);
    return {o, b, d, q};
  endfunction

  task automatic chk(input string tag, input logic [10:0] exp);
    vectors++;
    assert ({ovr, busy, done, out} === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed {ovr,busy,done,out}=%h expected %h", tag, {ovr, busy, done, out}, exp);
    end
  endtask

  function automatic int model_len();
    int l = 0;
    for (int i = 0; i < 8; i++)
      if (m_act_wid[i] != 0 && m_act_dly[i] + m_act_wid[i] > l)
        l = m_act_dly[i] + m_act_wid[i];
    return l;
  endfunction

  function automatic logic [7:0] model_out(input int k);
    logic [7:0] r = '0;
    for (int i = 0; i < 8; i++)
      r[i] = (m_act_wid[i] != 0) && (k >= m_act_dly[i]) && (k < m_act_dly[i] + m_act_wid[i]);
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_sh_dly[i] = 0;
      m_sh_wid[i] = 0;
    end
    m_ovr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_clear();
    chk("reset", mk(0, 0, 0, 8'h00));
  endtask

  task automatic cfg_write(input bit is_wid, input int ch, input int data);
    logic [2:0] c;
    logic [15:0] d;
    c = ch[2:0];
    d = data[15:0];
    cfg_we   = 1'b1;
    cfg_addr = {is_wid, c};
    cfg_data = d;
    tick();
    cfg_we = 1'b0;
    if (is_wid) m_sh_wid[c] = d & 16'h00FF;
    else        m_sh_dly[c] = d;
  endtask

  // One trigger run. poke_k: at run cycle k write ch2 wid=2 and re-trigger.
  // abort_k / rst_k: assert abort / rst so it is sampled at the edge with cnt=k.
  task automatic run(input int abort_k, input int poke_k, input int rst_k, input bit abort_acc);
    int l;
    for (int i = 0; i < 8; i++) begin
      m_act_dly[i] = m_sh_dly[i];
      m_act_wid[i] = m_sh_wid[i];
    end
    l = model_len();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    chk("run_e0", mk(m_ovr, 0, 0, 8'h00));
    tick();
    chk("run_e1", mk(m_ovr, 0, 0, 8'h00));
    abort = abort_acc;
    tick();
    abort = 1'b0;
    chk("run_accept", mk(m_ovr, 1, 0, 8'h00));
    for (int k = 0; k <= l; k++) begin
      if (k == poke_k) begin
        trig = 1'b1;
        cfg_we = 1'b1;
        cfg_addr = 4'hA;
        cfg_data = 16'd2;
      end
      if (k == abort_k) abort = 1'b1;
      if (k == rst_k) rst = 1'b1;
      tick();
      trig = 1'b0;
      cfg_we = 1'b0;
      abort = 1'b0;
      rst = 1'b0;
      if (k == poke_k) m_sh_wid[2] = 2;
      if (poke_k >= 0 && k >= poke_k + 2) m_ovr = 1'b1;
      if (k == rst_k) begin
        model_clear();
        chk("run_rst", mk(0, 0, 0, 8'h00));
        tick();
        chk("run_rst_idle", mk(0, 0, 0, 8'h00));
        return;
      end
      if (k == abort_k) begin
        chk("run_abort", mk(m_ovr, 0, 0, 8'h00));
        tick();
        chk("run_abort_idle", mk(m_ovr, 0, 0, 8'h00));
        return;
      end
      if (k < l) chk("run_out", mk(m_ovr, 1, 0, model_out(k)));
      else       chk("run_done", mk(m_ovr, 0, 1, 8'h00));
    end
    tick();
    chk("run_idle", mk(m_ovr, 0, 0, 8'h00));
  endtask

  initial begin
    model_clear();
    do_reset();

    // Two channels with distinct delay/width; L = 8.
    cfg_write(0, 0, 5);
    cfg_write(1, 0, 3);
    cfg_write(0, 7, 0);
    cfg_write(1, 7, 1);
    run(-1, -1, -1, 1'b0);

    // All channels disabled: one busy cycle, done only.
    do_reset();
    run(-1, -1, -1, 1'b0);

    // Mid-run shadow write plus re-trigger: run unchanged, ovr sticks,
    // next run uses the new width.
    do_reset();
    cfg_write(0, 2, 10);
    cfg_write(1, 2, 20);
    run(-1, 3, -1, 1'b0);
    run(-1, -1, -1, 1'b0);

    // Abort at cnt=4, then a full run; also abort coincident with accept.
    do_reset();
    cfg_write(0, 1, 2);
    cfg_write(1, 1, 10);
    run(4, -1, -1, 1'b0);
    run(-1, -1, -1, 1'b1);

    // Randomized configurations, some with aborts; width writes carry
    // junk in the upper data bits.
    do_reset();
    for (int r = 0; r < 8; r++) begin
      int ak;
      for (int w = 0; w < 6; w++) begin
        int ch;
        ch = $urandom_range(0, 7);
        if ($urandom_range(0, 1) == 1)
          cfg_write(1, ch, (($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15)) |
                           ($urandom_range(0, 255) << 8));
        else
          cfg_write(0, ch, $urandom_range(0, 40));
      end
      ak = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : -1;
      run(ak, -1, -1, 1'b0);
    end

    // Boundary: maximum delay and width, no counter wrap.
    do_reset();
    cfg_write(0, 3, 16'hFFFF);
    cfg_write(1, 3, 255);
    run(-1, -1, -1, 1'b0);

    // Reset mid-run clears shadows; next trigger yields done only.
    cfg_write(0, 1, 2);
    cfg_write(1, 1, 10);
    run(-1, -1, 5, 1'b0);
    run(-1, -1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
